// File: rtl/breakout_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// breakout_game_ctrl_if
// Bundle of the signals exchanged between the Breakout game-state controller
// and the rest of the game (input sources, text overlay, graphics engine).
//
//   refr_tick   : one-cycle pulse per video frame (start of vertical blank)
//   btn[1:0]    : debounced player buttons, level; any bit high = pressed
//   miss        : one-cycle pulse, ball left through the bottom edge
//   all_cleared : level, no bricks remain
//   ball[2:0]   : balls remaining
//   won         : last game ended with all bricks cleared
//   gra_still   : graphics frozen
//   ball_reload : one-cycle pulse, graphics re-centres and launches the ball
//   show_rule   : rule text enabled
//   show_over   : end-of-game text enabled
//
// Modports: master drives the game inputs and observes the controller
// outputs; slave is the controller side.
// -----------------------------------------------------------------------------
interface breakout_game_ctrl_if;
  logic       refr_tick;
  logic [1:0] btn;
  logic       miss;
  logic       all_cleared;
  logic [2:0] ball;
  logic       won;
  logic       gra_still;
  logic       ball_reload;
  logic       show_rule;
  logic       show_over;

  modport master (
    output refr_tick, btn, miss, all_cleared,
    input  ball, won, gra_still, ball_reload, show_rule, show_over
  );

  modport slave (
    input  refr_tick, btn, miss, all_cleared,
    output ball, won, gra_still, ball_reload, show_rule, show_over
  );
endinterface

// File: rtl/breakout_game_ctrl.sv
// -----------------------------------------------------------------------------
// breakout_game_ctrl
// Game-state controller for Breakout. Sequences NEWGAME -> PLAY -> NEWBALL /
// OVER, tracks balls remaining and the win/lose outcome, and runs the frame-
// counted delay used between balls and after the game ends.
//
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : breakout_game_ctrl_if.slave (game inputs in, overlay/graphics out)
//
// Parameters:
//   BALLS_INIT   : balls granted at new game (1..7)
//   DELAY_FRAMES : new-ball / game-over delay in refresh ticks (1..255)
//
// All outputs are registered and are derived from the next state, so they
// always describe the state the controller is in after the clock edge.
// -----------------------------------------------------------------------------
module breakout_game_ctrl #(
  parameter int BALLS_INIT   = 3,
  parameter int DELAY_FRAMES = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  breakout_game_ctrl_if.slave   bus
);

  localparam logic [2:0] S_NEWGAME = 3'd0;
  localparam logic [2:0] S_PLAY    = 3'd1;
  localparam logic [2:0] S_NEWBALL = 3'd2;
  localparam logic [2:0] S_OVER    = 3'd3;

  localparam logic [2:0] BALLS_RST = 3'(BALLS_INIT);
  localparam logic [7:0] DELAY_LD  = 8'(DELAY_FRAMES);

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] ball_q, ball_d;
  logic       won_q, won_d;
  logic       still_q, still_d;
  logic       reload_q, reload_d;
  logic       rule_q, rule_d;
  logic       over_q, over_d;

  logic       btnPressed;
  logic       timerDone;
  logic       timerLoad;

  assign btnPressed = |bus.btn;
  assign timerDone  = (timer_q == 8'd0);

  // Phase sequencing plus ball/won bookkeeping. In PLAY a clear takes
  // priority over a simultaneous miss, so a winning last brick never costs
  // a ball. A miss at ball<=1 (including a forced ball==0) ends the game.
  always_comb begin
    state_d   = state_q;
    ball_d    = ball_q;
    won_d     = won_q;
    timerLoad = 1'b0;
    case (state_q)
      S_NEWGAME: begin
        ball_d = BALLS_RST;
        if (btnPressed) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.all_cleared) begin
          state_d   = S_OVER;
          won_d     = 1'b1;
          timerLoad = 1'b1;
        end else if (bus.miss) begin
          timerLoad = 1'b1;
          if (ball_q > 3'd1) begin
            ball_d  = ball_q - 3'd1;
            state_d = S_NEWBALL;
          end else begin
            ball_d  = 3'd0;
            won_d   = 1'b0;
            state_d = S_OVER;
          end
        end
      end
      S_NEWBALL: begin
        if (timerDone && btnPressed) state_d = S_PLAY;
      end
      S_OVER: begin
        if (timerDone) begin
          state_d = S_NEWGAME;
          ball_d  = BALLS_RST;
          won_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_NEWGAME;
        ball_d  = BALLS_RST;
        won_d   = 1'b0;
      end
    endcase
  end

  // Delay timer: a load always beats a coincident refresh tick, and the
  // count saturates at zero.
  always_comb begin
    timer_d = timer_q;
    if (timerLoad)
      timer_d = DELAY_LD;
    else if (bus.refr_tick && !timerDone)
      timer_d = timer_q - 8'd1;
  end

  // Output decode from the next state. The reload pulse fires only on the
  // edge that enters PLAY, so it can never last more than one cycle.
  always_comb begin
    still_d  = (state_d != S_PLAY);
    rule_d   = (state_d == S_NEWGAME);
    over_d   = (state_d == S_OVER);
    reload_d = (state_d == S_PLAY) && (state_q != S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_NEWGAME;
      timer_q  <= 8'd0;
      ball_q   <= BALLS_RST;
      won_q    <= 1'b0;
      still_q  <= 1'b1;
      reload_q <= 1'b0;
      rule_q   <= 1'b1;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ball_q   <= ball_d;
      won_q    <= won_d;
      still_q  <= still_d;
      reload_q <= reload_d;
      rule_q   <= rule_d;
      over_q   <= over_d;
    end
  end

  assign bus.ball        = ball_q;
  assign bus.won         = won_q;
  assign bus.gra_still   = still_q;
  assign bus.ball_reload = reload_q;
  assign bus.show_rule   = rule_q;
  assign bus.show_over   = over_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_breakout_game_ctrl
// Self-checking bench for breakout_game_ctrl. Instance A uses the default
// parameters (3 balls, 120-frame delay); instance B uses 7 balls and a
// 1-frame delay to exercise the load-versus-tick corner.
// Outputs are compared as a packed byte:
//   {ball[2:0], won, gra_still, ball_reload, show_rule, show_over}
// -----------------------------------------------------------------------------
module tb_breakout_game_ctrl;

  typedef struct {
    logic       refr;
    logic [1:0] btn;
    logic       miss;
    logic       clr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic rstA;
  logic rstB;
  int   checks;
  int   errors;
  bit   sawReload;

  breakout_game_ctrl_if ifA ();
  breakout_game_ctrl_if ifB ();

  breakout_game_ctrl #(.BALLS_INIT(3), .DELAY_FRAMES(120)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (ifA)
  );

  breakout_game_ctrl #(.BALLS_INIT(7), .DELAY_FRAMES(1)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input int b, input bit w, input bit s,
                                    input bit r, input bit ru, input bit ov);
    logic [2:0] b3;
    b3 = 3'(b);
    return {b3, w, s, r, ru, ov};
  endfunction

  function automatic logic [7:0] packA();
    return {ifA.ball, ifA.won, ifA.gra_still, ifA.ball_reload, ifA.show_rule, ifA.show_over};
  endfunction

  function automatic logic [7:0] packB();
    return {ifB.ball, ifB.won, ifB.gra_still, ifB.ball_reload, ifB.show_rule, ifB.show_over};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock of stimulus; outputs are settled #1 after the edge on return.
  task automatic applyStimulus(input bit sel, input logic refr, input logic [1:0] btn,
                               input logic miss, input logic clr);
    if (!sel) begin
      ifA.refr_tick = refr; ifA.btn = btn; ifA.miss = miss; ifA.all_cleared = clr;
    end else begin
      ifB.refr_tick = refr; ifB.btn = btn; ifB.miss = miss; ifB.all_cleared = clr;
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      if (ifA.ball_reload) sawReload = 1'b1;
    end else begin
      if (ifB.ball_reload) sawReload = 1'b1;
    end
  endtask

  task automatic runCycles(input bit sel, input int n, input logic refr, input logic [1:0] btn);
    sawReload = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(sel, refr, btn, 1'b0, 1'b0);
  endtask

  task automatic stepA(input logic refr, input logic [1:0] btn, input logic miss,
                       input logic clr, input logic [7:0] exp, input string name);
    applyStimulus(1'b0, refr, btn, miss, clr);
    checkOutput(name, packA(), exp);
  endtask

  vec_t vecA[4];
  vec_t vecB[6];

  initial begin
    checks = 0;
    errors = 0;
    sawReload = 1'b0;

    vecA[0] = '{1'b0, 2'b01, 1'b0, 1'b0, mk(3,0,0,1,0,0), "a_start_reload"};
    vecA[1] = '{1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,0,0,0,0), "a_play"};
    vecA[2] = '{1'b0, 2'b00, 1'b1, 1'b0, mk(2,0,1,0,0,0), "a_miss_to_newball"};
    vecA[3] = '{1'b1, 2'b01, 1'b1, 1'b1, mk(2,0,1,0,0,0), "a_newball_ignores"};

    vecB[0] = '{1'b0, 2'b01, 1'b0, 1'b0, mk(7,0,0,1,0,0), "b_start"};
    vecB[1] = '{1'b1, 2'b00, 1'b1, 1'b0, mk(6,0,1,0,0,0), "b_miss_tick_on_load"};
    vecB[2] = '{1'b0, 2'b01, 1'b0, 1'b0, mk(6,0,1,0,0,0), "b_timer_still_one"};
    vecB[3] = '{1'b1, 2'b01, 1'b0, 1'b0, mk(6,0,1,0,0,0), "b_timer_expires"};
    vecB[4] = '{1'b0, 2'b01, 1'b0, 1'b0, mk(6,0,0,1,0,0), "b_restart"};
    vecB[5] = '{1'b0, 2'b01, 1'b0, 1'b0, mk(6,0,0,0,0,0), "b_reload_single"};

    ifA.refr_tick = 0; ifA.btn = 0; ifA.miss = 0; ifA.all_cleared = 0;
    ifB.refr_tick = 0; ifB.btn = 0; ifB.miss = 0; ifB.all_cleared = 0;

    // Reset values on both instances.
    rstA = 1'b1;
    rstB = 1'b1;
    #1;
    checkOutput("a_reset", packA(), mk(3,0,1,0,1,0));
    checkOutput("b_reset", packB(), mk(7,0,1,0,1,0));
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0;

    // Idle in NEWGAME with no buttons.
    runCycles(1'b0, 1000, 1'b0, 2'b00);
    checkOutput("a_idle_no_reload", {7'd0, sawReload}, 8'd0);
    checkOutput("a_idle_newgame", packA(), mk(3,0,1,0,1,0));

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, vecA[i].refr, vecA[i].btn, vecA[i].miss, vecA[i].clr);
      checkOutput(vecA[i].name, packA(), vecA[i].exp);
    end

    // Button held through the delay; vecA[3] supplied tick 1 of 120.
    runCycles(1'b0, 118, 1'b1, 2'b01);
    checkOutput("a_tick119_no_reload", {7'd0, sawReload}, 8'd0);
    checkOutput("a_tick119_state", packA(), mk(2,0,1,0,0,0));
    stepA(1'b1, 2'b01, 1'b0, 1'b0, mk(2,0,1,0,0,0), "a_tick120_still");
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(2,0,0,1,0,0), "a_held_btn_reload");
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(2,0,0,0,0,0), "a_reload_one_cycle");

    // Second miss, restart by a fresh press after the delay.
    stepA(1'b0, 2'b00, 1'b1, 1'b0, mk(1,0,1,0,0,0), "a_miss2");
    runCycles(1'b0, 120, 1'b1, 2'b00);
    checkOutput("a_newball_waits_btn", packA(), mk(1,0,1,0,0,0));
    stepA(1'b0, 2'b10, 1'b0, 1'b0, mk(1,0,0,1,0,0), "a_restart2");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(1,0,0,0,0,0), "a_play2");

    // Last ball lost: game over, buttons ignored, automatic return.
    stepA(1'b0, 2'b00, 1'b1, 1'b0, mk(0,0,1,0,0,1), "a_game_over");
    runCycles(1'b0, 119, 1'b1, 2'b11);
    checkOutput("a_over_btn_ignored", {7'd0, sawReload}, 8'd0);
    checkOutput("a_over_hold", packA(), mk(0,0,1,0,0,1));
    stepA(1'b1, 2'b00, 1'b0, 1'b0, mk(0,0,1,0,0,1), "a_over_tick120");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,1,0,1,0), "a_back_to_newgame");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,1,0,1,0), "a_newgame_stays");

    // Win with a simultaneous miss at ball=2.
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(3,0,0,1,0,0), "w_start");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,0,0,0,0), "w_play");
    stepA(1'b0, 2'b00, 1'b1, 1'b0, mk(2,0,1,0,0,0), "w_miss");
    runCycles(1'b0, 120, 1'b1, 2'b00);
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(2,0,0,1,0,0), "w_restart");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(2,0,0,0,0,0), "w_play2");
    stepA(1'b0, 2'b00, 1'b1, 1'b1, mk(2,1,1,0,0,1), "w_clear_beats_miss");
    stepA(1'b0, 2'b00, 1'b1, 1'b0, mk(2,1,1,0,0,1), "w_over_ignores_miss");
    runCycles(1'b0, 120, 1'b1, 2'b00);
    checkOutput("w_won_held", packA(), mk(2,1,1,0,0,1));
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,1,0,1,0), "w_won_cleared");

    // Reset in NEWBALL with the timer at 57, button held across release.
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(3,0,0,1,0,0), "r_start");
    stepA(1'b0, 2'b00, 1'b0, 1'b0, mk(3,0,0,0,0,0), "r_play");
    stepA(1'b0, 2'b00, 1'b1, 1'b0, mk(2,0,1,0,0,0), "r_miss");
    runCycles(1'b0, 63, 1'b1, 2'b00);
    ifA.btn = 2'b01;
    rstA = 1'b1;
    #1;
    checkOutput("r_async_reset", packA(), mk(3,0,1,0,1,0));
    runCycles(1'b0, 3, 1'b0, 2'b01);
    checkOutput("r_held_no_reload", {7'd0, sawReload}, 8'd0);
    rstA = 1'b0;
    stepA(1'b0, 2'b01, 1'b0, 1'b0, mk(3,0,0,1,0,0), "r_release_reload");
    runCycles(1'b0, 5, 1'b0, 2'b01);
    checkOutput("r_single_pulse", {7'd0, sawReload}, 8'd0);
    checkOutput("r_in_play", packA(), mk(3,0,0,0,0,0));

    // Instance B: 7 balls, 1-frame delay.
    rstB = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecB[i].refr, vecB[i].btn, vecB[i].miss, vecB[i].clr);
      checkOutput(vecB[i].name, packB(), vecB[i].exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
Top-level game-state controller for the Breakout game. It sequences the game through new-game, play, new-ball and over phases. It tracks the remaining-ball count and win/lose outcome, and runs the inter-phase delay timer. Its outputs feed the text overlay (ball digit, won flag, rule/over display enables) and the graphics engine (freeze and ball-reload controls).

Parameters:
BALLS_INIT, 3, balls granted at new game; legal range 1..7 because the count is rendered as ASCII 0x30+ball.
DELAY_FRAMES, 120, length of the new-ball and game-over delay in refresh ticks (2 s at 60 Hz); legal range 1..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
refr_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
btn  in  2  debounced player buttons, level; any bit high counts as "pressed"
miss  in  1  one-cycle pulse: ball left through the bottom edge
all_cleared  in  1  level: no bricks remain
ball  out  3  balls remaining, unsigned
won  out  1  1 = last game ended with all bricks cleared
gra_still  out  1  1 = graphics frozen (ball/paddle held)
ball_reload  out  1  one-cycle pulse: graphics re-centres the ball and starts its motion
show_rule  out  1  rule text enabled
show_over  out  1  end-of-game text enabled (WIN or GAME OVER, chosen by won)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=NEWGAME, ball=BALLS_INIT, won=0, gra_still=1, ball_reload=0, show_rule=1, show_over=0, timer=0.
- All outputs are registered. An input sampled at edge N is reflected at outputs after edge N (1-cycle latency).
- Delay timer, 8-bit down-counter:
  - Loaded with DELAY_FRAMES on entry to NEWBALL or OVER.
  - Decrements on refr_tick while nonzero; never wraps below 0.
  - timer_done = (timer==0).
  - A refr_tick coinciding with the load cycle is ignored; the load wins.
- NEWGAME:
  - Outputs: gra_still=1, show_rule=1, show_over=0. ball held at BALLS_INIT.
  - btn!=0 -> PLAY; ball_reload=1 for exactly that transition cycle.
- PLAY:
  - Outputs: gra_still=0, show_rule=0, show_over=0.
  - all_cleared=1 -> OVER, won=1, timer loaded, ball unchanged.
  - Else miss=1 and ball>1 -> ball=ball-1, NEWBALL, timer loaded.
  - Else miss=1 and ball==1 -> ball=0, won=0, OVER, timer loaded.
  - all_cleared and miss in the same cycle: all_cleared has priority (win, no decrement).
  - ball never underflows. miss with ball==0 cannot occur in PLAY; if forced, treat it as the ball==1 case and keep ball=0.
- NEWBALL:
  - Output: gra_still=1.
  - timer_done AND btn!=0 -> PLAY with a ball_reload pulse.
  - A button held through the whole delay starts play on the first cycle timer_done is true.
  - miss and all_cleared are ignored.
- OVER:
  - Outputs: gra_still=1, show_over=1; won held.
  - timer_done -> NEWGAME. On that transition ball=BALLS_INIT and won=0; buttons are ignored.
- ball_reload is never high for more than one consecutive cycle and only on transitions into PLAY.
- Reset asserted mid-game (any state, any timer value) immediately forces reset values. No pulse is emitted after reset deasserts until a new button press in NEWGAME.
- Unused state encodings recover to NEWGAME on the next clock.

Test Plan:
- Reset then release, btn=00 for 1000 cycles -> state NEWGAME, ball=3, show_rule=1, gra_still=1, ball_reload never asserted; press btn=01 -> ball_reload high exactly 1 cycle, gra_still=0 next cycle.
- In PLAY, pulse miss -> ball=2 next cycle, gra_still=1. btn held; ball_reload asserts only after 120 refr_ticks, not at tick 119.
- Three misses with intervening restarts -> ball 3->2->1->0, won=0, show_over=1. After 120 refr_ticks -> NEWGAME with ball=3, show_over=0, no button needed.
- In PLAY with ball=2, assert miss and all_cleared in the same cycle -> won=1, ball stays 2, state OVER. won returns to 0 on re-entry to NEWGAME.
- Assert rst during NEWBALL with timer=57 -> ball=3, gra_still=1, no ball_reload. Releasing rst with btn held -> PLAY entered once, single reload pulse.
- DELAY_FRAMES=1, BALLS_INIT=7: miss then refr_tick on the load cycle -> timer still 1, expires on the next refr_tick. ball output reads 6 (ASCII '6' downstream).
